// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one combinational ALU between two
// requesters, one op in flight, tagged response with valid/ready.
// Ports: clk/rst (sync, active-high); req0_*/req1_* operation inputs with
// valid/ready; alu_* registered ops out to the ALU, alu_c plus flags back in;
// rsp_* tagged response channel; busy (state != IDLE).
// Optional: define ALU_SHARE_ARB_STATS_EN to add the saturating grant
// counters grant_cnt0/grant_cnt1 (CNT_WIDTH bits) and the stats_clr input.
module alu_share_arb #(
    parameter int DATA_WIDTH = 64
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_in1,
    input  logic [DATA_WIDTH-1:0] req0_in2,
    input  logic [3:0]            req0_func3,
    input  logic [3:0]            req0_func7,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_in1,
    input  logic [DATA_WIDTH-1:0] req1_in2,
    input  logic [3:0]            req1_func3,
    input  logic [3:0]            req1_func7,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [3:0]            alu_func3,
    output logic [3:0]            alu_func7,
    input  logic [DATA_WIDTH-1:0] alu_c,
    input  logic                  alu_zero,
    input  logic                  alu_cout,
    input  logic                  alu_overflow,
    input  logic                  alu_sign,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [3:0]            rsp_flags,
`ifdef ALU_SHARE_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q;
    logic                  id_q;
    logic [DATA_WIDTH-1:0] in1_q, in2_q;
    logic [3:0]            func3_q, func7_q;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [3:0]            rsp_flags_q;

    logic can_accept, grant0, grant1, accept;

    // last_grant_q==1 means req0 wins the next tie.
    always_comb begin
        can_accept = !rst &&
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && !grant0;
        accept     = can_accept && (grant0 || grant1);
    end

    assign req0_ready = can_accept && grant0;
    assign req1_ready = can_accept && grant1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            in1_q        <= '0;
            in2_q        <= '0;
            func3_q      <= '0;
            func7_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                in1_q        <= grant1 ? req1_in1 : req0_in1;
                in2_q        <= grant1 ? req1_in2 : req0_in2;
                func3_q      <= grant1 ? req1_func3 : req0_func3;
                func7_q      <= grant1 ? req1_func7 : req0_func7;
                id_q         <= grant1;
                last_grant_q <= grant1;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_data_q  <= alu_c;
                rsp_flags_q <= {alu_overflow, alu_sign, alu_cout, alu_zero};
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_func3 = func3_q;
    assign alu_func7 = func7_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

    // Clear has priority over a same-edge increment; counts saturate.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept && grant0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (accept && grant1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vectors and hand-written sequences for
// alu_share_arb, with a small add/sub ALU model on the alu_* ports.
module tb_alu_share_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [63:0] req0_in1, req0_in2;
    logic [3:0]  req0_func3, req0_func7;
    logic        req1_valid, req1_ready;
    logic [63:0] req1_in1, req1_in2;
    logic [3:0]  req1_func3, req1_func7;
    logic [63:0] alu_in1, alu_in2;
    logic [3:0]  alu_func3, alu_func7;
    logic [63:0] alu_c;
    logic        alu_zero, alu_cout, alu_overflow, alu_sign;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        busy;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic        stats_clr;
    logic [7:0]  grant_cnt0, grant_cnt1;
`endif

    int nchecks = 0;
    int nerrors = 0;

`ifdef ALU_SHARE_ARB_STATS_EN
    alu_share_arb #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut (
`else
    alu_share_arb #(.DATA_WIDTH(64)) dut (
`endif
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req0_func3(req0_func3), .req0_func7(req0_func7),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .req1_func3(req1_func3), .req1_func7(req1_func7),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_c(alu_c), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
`ifdef ALU_SHARE_ARB_STATS_EN
        .stats_clr(stats_clr),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .busy(busy)
    );

    // Shared ALU stand-in: func7==2 subtracts, everything else adds.
    logic        is_sub;
    logic [63:0] opb;
    logic [64:0] sum;
    always_comb begin
        is_sub       = (alu_func7 == 4'h2);
        opb          = is_sub ? ~alu_in2 : alu_in2;
        sum          = {1'b0, alu_in1} + {1'b0, opb} + {64'd0, is_sub};
        alu_c        = sum[63:0];
        alu_cout     = sum[64];
        alu_zero     = (sum[63:0] == 64'd0);
        alu_sign     = sum[63];
        alu_overflow = (alu_in1[63] == opb[63]) && (sum[63] != alu_in1[63]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        sel;
        logic [63:0] in1;
        logic [63:0] in2;
        logic [3:0]  f3;
        logic [3:0]  f7;
        logic [63:0] exp_data;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[6];

    int          g_order[$];
    int          exp_id[$];
    logic [63:0] exp_dat[$];

    initial begin
        int n0, n1, cyc, last_acc, g, id_e;
        logic [63:0] d_e;

        vecs[0] = '{1'b0, 64'd5, 64'd3, 4'h0, 4'h0, 64'd8, 4'b0000};
        vecs[1] = '{1'b1, 64'd5, 64'd3, 4'h0, 4'h2, 64'd2, 4'b0010};
        vecs[2] = '{1'b1, 64'd0, 64'd1, 4'h0, 4'h2,
                    64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
        vecs[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 4'h0,
                    64'h8000_0000_0000_0000, 4'b1100};
        vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 4'h0,
                    64'd0, 4'b0011};
        vecs[5] = '{1'b0, 64'd1, 64'd2, 4'hA, 4'h5, 64'd3, 4'b0000};

        rst = 1'b1;
        req0_valid = 1'b1; req0_in1 = '0; req0_in2 = '0;
        req0_func3 = '0; req0_func7 = '0;
        req1_valid = 1'b1; req1_in1 = '0; req1_in2 = '0;
        req1_func3 = '0; req1_func7 = '0;
        rsp_ready = 1'b1;
`ifdef ALU_SHARE_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick;
        check("rst_ready0", {63'd0, req0_ready}, 64'd0);
        check("rst_ready1", {63'd0, req1_ready}, 64'd0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        check("rst_alu_in1", alu_in1, 64'd0);
        check("rst_alu_in2", alu_in2, 64'd0);
        tick;

        // Contention: both requesters hold valid for three ops each.
        n0 = 0; n1 = 0; cyc = 0; last_acc = -1;
        req0_valid = 1'b1; req0_in1 = 64'd100; req0_in2 = 64'd1;
        req1_valid = 1'b1; req1_in1 = 64'd200; req1_in2 = 64'd20;
        while ((n0 < 3 || n1 < 3 || exp_id.size() > 0) && cyc < 60) begin
            #1;
            g = -1;
            if (req0_ready) g = 0;
            else if (req1_ready) g = 1;
            if (req0_ready && req1_ready)
                check("both_ready", 64'd1, 64'd0);
            if (g >= 0) begin
                g_order.push_back(g);
                exp_id.push_back(g);
                exp_dat.push_back(g == 1 ? req1_in1 + req1_in2
                                         : req0_in1 + req0_in2);
                if (last_acc >= 0)
                    check("throughput", 64'(cyc - last_acc), 64'd2);
                last_acc = cyc;
            end
            if (rsp_valid) begin
                if (exp_id.size() == 0) begin
                    check("cont_spurious_rsp", 64'd1, 64'd0);
                end else begin
                    id_e = exp_id.pop_front();
                    d_e = exp_dat.pop_front();
                    check("cont_rsp_id", {63'd0, rsp_id}, 64'(id_e));
                    check("cont_rsp_data", rsp_data, d_e);
                end
            end
            tick;
            cyc++;
            if (g == 0) begin
                n0++;
                req0_in1 = 64'd100 + 64'(n0 * 7);
                req0_in2 = 64'd1 + 64'(n0);
                if (n0 == 3) req0_valid = 1'b0;
            end else if (g == 1) begin
                n1++;
                req1_in1 = 64'd200 + 64'(n1 * 11);
                req1_in2 = 64'd20 + 64'(n1);
                if (n1 == 3) req1_valid = 1'b0;
            end
        end
        check("cont_done", 64'(exp_id.size()), 64'd0);
        check("cont_grants", 64'(g_order.size()), 64'd6);
        foreach (g_order[i])
            check("cont_order", 64'(g_order[i]), 64'(i % 2));
        tick;

        // Single ops from the vector table, rsp_ready held high.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sel) begin
                req1_valid = 1'b1; req1_in1 = vecs[i].in1;
                req1_in2 = vecs[i].in2; req1_func3 = vecs[i].f3;
                req1_func7 = vecs[i].f7;
            end else begin
                req0_valid = 1'b1; req0_in1 = vecs[i].in1;
                req0_in2 = vecs[i].in2; req0_func3 = vecs[i].f3;
                req0_func7 = vecs[i].f7;
            end
            #1;
            check("vec_ready", {63'd0, vecs[i].sel ? req1_ready : req0_ready},
                  64'd1);
            tick;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check("vec_ready_pulse",
                  {63'd0, vecs[i].sel ? req1_ready : req0_ready}, 64'd0);
            check("vec_exec_busy", {63'd0, busy}, 64'd1);
            check("vec_exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("vec_alu_in1", alu_in1, vecs[i].in1);
            check("vec_alu_in2", alu_in2, vecs[i].in2);
            check("vec_alu_func3", {60'd0, alu_func3}, {60'd0, vecs[i].f3});
            check("vec_alu_func7", {60'd0, alu_func7}, {60'd0, vecs[i].f7});
            tick;
            check("vec_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("vec_rsp_id", {63'd0, rsp_id}, {63'd0, vecs[i].sel});
            check("vec_rsp_data", rsp_data, vecs[i].exp_data);
            check("vec_rsp_flags", {60'd0, rsp_flags},
                  {60'd0, vecs[i].exp_flags});
            tick;
            check("vec_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("vec_idle_busy", {63'd0, busy}, 64'd0);
            check("vec_hold_alu_in1", alu_in1, vecs[i].in1);
        end
        req0_func3 = '0; req0_func7 = '0;
        req1_func3 = '0; req1_func7 = '0;

        // Backpressure, then retire and accept on the same edge.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_in1 = 64'd7; req0_in2 = 64'd1;
        tick;
        req0_valid = 1'b0;
        tick;
        check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        req1_valid = 1'b1; req1_in1 = 64'd20; req1_in2 = 64'd22;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_data_hold", rsp_data, 64'd8);
            check("bp_rsp_id_hold", {63'd0, rsp_id}, 64'd0);
            check("bp_rsp_flags_hold", {60'd0, rsp_flags}, 64'd0);
            check("bp_ready0", {63'd0, req0_ready}, 64'd0);
            check("bp_ready1", {63'd0, req1_ready}, 64'd0);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_retire_ready1", {63'd0, req1_ready}, 64'd1);
        tick;
        req1_valid = 1'b0;
        check("bp_retire_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("bp_retire_busy", {63'd0, busy}, 64'd1);
        check("bp_new_alu_in1", alu_in1, 64'd20);
        tick;
        check("bp_new_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("bp_new_rsp_id", {63'd0, rsp_id}, 64'd1);
        check("bp_new_rsp_data", rsp_data, 64'd42);
        tick;

        // Reset while the op is in EXEC.
        req0_valid = 1'b1; req0_in1 = 64'd9; req0_in2 = 64'd1;
        tick;
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        req1_valid = 1'b1; req1_in1 = 64'd30; req1_in2 = 64'd3;
        #1;
        check("mid_rst_ready0", {63'd0, req0_ready}, 64'd0);
        check("mid_rst_ready1", {63'd0, req1_ready}, 64'd0);
        tick;
        rst = 1'b0;
        check("mid_busy0", {63'd0, busy}, 64'd0);
        check("mid_rsp_valid0", {63'd0, rsp_valid}, 64'd0);
        check("mid_alu_in1", alu_in1, 64'd0);
        check("mid_rsp_data", rsp_data, 64'd0);
        #1;
        check("mid_first_ready0", {63'd0, req0_ready}, 64'd1);
        check("mid_first_ready1", {63'd0, req1_ready}, 64'd0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mid_first_alu_in1", alu_in1, 64'd9);
        tick;
        check("mid_first_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("mid_first_rsp_data", rsp_data, 64'd10);
        tick;

`ifdef ALU_SHARE_ARB_STATS_EN
        check("cnt0_after_rst", {56'd0, grant_cnt0}, 64'd1);
        check("cnt1_after_rst", {56'd0, grant_cnt1}, 64'd0);
        n0 = 0; cyc = 0;
        req0_valid = 1'b1; req0_in1 = 64'd1; req0_in2 = 64'd1;
        while (n0 < 300 && cyc < 2000) begin
            #1;
            if (req0_ready) n0++;
            tick;
            cyc++;
            if (n0 == 300) req0_valid = 1'b0;
        end
        check("sat_accepts", 64'(n0), 64'd300);
        check("sat_cnt0", {56'd0, grant_cnt0}, 64'd255);
        tick;
        tick;
        req0_valid = 1'b1;
        stats_clr = 1'b1;
        #1;
        check("clr_accept_ready", {63'd0, req0_ready}, 64'd1);
        tick;
        stats_clr = 1'b0;
        req0_valid = 1'b0;
        check("clr_cnt0", {56'd0, grant_cnt0}, 64'd0);
        check("clr_cnt1", {56'd0, grant_cnt1}, 64'd0);
        tick;
        tick;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
